cap_prop_stim_gen: RTL and testbench
====================================

Name: cap_prop_stim_gen

Overview:
- Sequential stimulus source and result collector for the capability property checkers (unique, exact, getBase, getTop, isInBounds, setAddr, and the rest).
- Drives (base, len, addr, newBase, newLen) tuples to a checker harness over a valid/ready handshake, then consumes the in-order pass/fail responses.
- Counts passes and failures and latches the first failing tuple.
- Sits above the checker wrappers in simulation and FPGA self-test builds.

Parameters:
- WIDTH, 32, width of every tuple field.
- NUM_VECTORS, 1024, total tuples per run, corner vectors included; must be 8 or more.
- MAX_OUTSTANDING, 4, maximum number of issued tuples still awaiting a response; 1 to 15.
- SEED, 32'hACE1_0001, LFSR load value on start; must be nonzero.
- STOP_ON_FAIL, 0, when 1 the block stops issuing after the first failing response.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a run; honoured only in IDLE or DONE.
- busy  out  1  high in CORNER, RANDOM and DRAIN.
- done  out  1  high in DONE.
- out_valid  out  1  tuple valid.
- out_ready  in  1  checker accepts the tuple.
- out_base, out_len, out_addr, out_newBase, out_newLen  out  WIDTH each  tuple fields.
- rsp_valid  in  1  checker response valid.
- rsp_ok  in  1  checker verdict; 1 means pass.
- pass_count, fail_count  out  16 each  saturating counters.
- first_fail_base, first_fail_len, first_fail_addr  out  WIDTH each  tuple of the first failure.
- proto_err  out  1  sticky flag: a response arrived while nothing was outstanding.

Behaviour:
- Reset (asynchronous, any state, including mid-run):
  - State goes to IDLE.
  - Every output goes to 0.
  - LFSR, issue index, outstanding counter and response FIFO are cleared.
- States and transitions:
  - IDLE or DONE, start=1 → CORNER. On entry: clear counters, first_fail_*, proto_err and the fail-latched flag; load LFSR=SEED; issue index=0.
  - CORNER → RANDOM after corner tuple 7 transfers.
  - RANDOM → DRAIN after tuple NUM_VECTORS-1 transfers, or on the first fail when STOP_ON_FAIL=1.
  - DRAIN → DONE when outstanding==0.
  - start is ignored while busy.
- Handshake:
  - A transfer happens on a cycle with out_valid && out_ready.
  - out_valid rises only in CORNER/RANDOM, and only when outstanding < MAX_OUTSTANDING.
  - Once raised, out_valid and all fields hold stable until the transfer; no withdrawal, even if a fail with STOP_ON_FAIL arrives meanwhile.
  - No out_valid in DRAIN, DONE or IDLE.
- Outstanding counter:
  - +1 on transfer, -1 on rsp_valid; both in the same cycle leaves it unchanged.
  - rsp_valid with outstanding==0 sets proto_err and is otherwise ignored.
- Response matching:
  - Responses are in order.
  - Each transferred tuple's (base, len, addr) is pushed into a MAX_OUTSTANDING-deep FIFO and popped on rsp_valid.
  - rsp_ok=1 → pass_count+1. rsp_ok=0 → fail_count+1; on the first fail, latch the popped tuple into first_fail_*.
  - Both counters saturate at 16'hFFFF.
- Corner tuples, index 0..7, given as base/len/addr:
  - 0: 0/0/0
  - 1: 0/FFFFFFFF/0
  - 2: FFFFFFFF/1/FFFFFFFF
  - 3: 1000/FFF/1800
  - 4: 80000000/80000000/FFFFFFFF
  - 5: 1/7FFFFFFF/0
  - 6: 12345678/10000/12355678
  - 7: FFFFF000/1000/FFFFFFFF
  - For all corner tuples: newBase = base+1, newLen = len.
- Random tuples (L = current LFSR value):
  - base = L
  - len = rotl(L,11) >> L[4:0]
  - addr = base + (len >> L[7:5])
  - newBase = base + rotl(L,5)[7:0]
  - newLen = len >> 1
  - All sums wrap modulo 2^WIDTH.
- LFSR:
  - 32-bit Galois, taps 32'h80200003.
  - Advances once per RANDOM transfer, and only on transfer, so fields stay stable while stalled.
- Latency:
  - First out_valid appears the cycle after start.
  - Back-to-back transfers are possible when out_ready stays high and outstanding < MAX.
  - done asserts the cycle after the last response.

Test Plan:
- Reset, start, out_ready=1, 1-cycle responder always ok, NUM_VECTORS=16 → corner tuple 0 is 0/0/0/1/0; tuple 3 is 1000/FFF/1800/1001/FFF; done; pass_count=16, fail_count=0.
- out_ready=0 for 5 cycles while tuple 2 is presented → fields stay FFFFFFFF/1/FFFFFFFF/0/1 every cycle; a single transfer occurs when out_ready rises.
- Responder withholds responses → out_valid drops after 4 transfers; one response re-enables issue; outstanding never exceeds 4.
- Responder returns rsp_ok=0 for tuple 4 only, STOP_ON_FAIL=1 → first_fail = 80000000/80000000/FFFFFFFF; no tuple index ≥ 4+MAX issued; DRAIN then DONE; fail_count=1.
- rsp_valid pulse while IDLE → proto_err=1, counters unchanged; a subsequent start clears proto_err.
- RST_N low while in RANDOM with 3 outstanding → all outputs 0, IDLE; a new start replays the identical tuple sequence from corner 0 with the LFSR at SEED.

Source files
------------

// File: rtl/cap_prop_stim_gen.sv
// cap_prop_stim_gen: issues corner and LFSR capability tuples to a checker over valid/ready and tallies its in-order verdicts
// Ports: CLK/RST_N clock and async active-low reset; start pulse begins a run (IDLE/DONE only);
// busy/done run status; out_valid/out_ready and out_* tuple fields toward the checker;
// rsp_valid/rsp_ok in-order verdicts; pass_count/fail_count saturating tallies;
// first_fail_* tuple of the first failing verdict; proto_err sticky response-without-request flag.
module cap_prop_stim_gen #(
  parameter int          WIDTH           = 32,
  parameter int          NUM_VECTORS     = 1024,
  parameter int          MAX_OUTSTANDING = 4,
  parameter logic [31:0] SEED            = 32'hACE1_0001,
  parameter bit          STOP_ON_FAIL    = 1'b0
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_base,
  output logic [WIDTH-1:0] out_len,
  output logic [WIDTH-1:0] out_addr,
  output logic [WIDTH-1:0] out_newBase,
  output logic [WIDTH-1:0] out_newLen,
  input  logic             rsp_valid,
  input  logic             rsp_ok,
  output logic [15:0]      pass_count,
  output logic [15:0]      fail_count,
  output logic [WIDTH-1:0] first_fail_base,
  output logic [WIDTH-1:0] first_fail_len,
  output logic [WIDTH-1:0] first_fail_addr,
  output logic             proto_err
);
  localparam int IW    = $clog2(NUM_VECTORS + 1);
  localparam int PW    = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int DEPTH = 2 ** PW;
  localparam logic [31:0] TAPS = 32'h8020_0003;
  localparam logic [31:0] CB [8] = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'h1000, 32'h8000_0000, 32'h1, 32'h1234_5678, 32'hFFFF_F000};
  localparam logic [31:0] CL [8] = '{32'h0, 32'hFFFF_FFFF, 32'h1, 32'hFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1_0000, 32'h1000};
  localparam logic [31:0] CA [8] = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'h1800, 32'hFFFF_FFFF, 32'h0, 32'h1235_5678, 32'hFFFF_FFFF};

  typedef enum logic [2:0] {IDLE, CORNER, RANDOM, DRAIN, DONE} state_t;
  typedef struct packed {
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] len;
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] new_base;
    logic [WIDTH-1:0] new_len;
  } tuple_t;
  typedef struct packed {
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] len;
    logic [WIDTH-1:0] addr;
  } entry_t;

  state_t        state, state_n;
  logic [IW-1:0] idx, idx_n;
  logic [31:0]   lfsr, lfsr_n;
  logic [3:0]    outstanding, outstanding_n;
  logic [PW-1:0] wr_ptr, rd_ptr;
  entry_t        fifo [DEPTH];
  logic          fail_latched;
  logic          start_ok, xfer, rsp_acc, issuing, stop, hold, valid_n;
  tuple_t        tup_n;

  function automatic tuple_t gen(input logic [IW-1:0] i, input logic [31:0] l);
    tuple_t      t;
    logic [31:0] r11;
    r11 = {l[20:0], l[31:21]};
    if (i < IW'(8)) begin
      t.base     = WIDTH'(CB[i[2:0]]);
      t.len      = WIDTH'(CL[i[2:0]]);
      t.addr     = WIDTH'(CA[i[2:0]]);
      t.new_base = t.base + WIDTH'(1);
      t.new_len  = t.len;
    end else begin
      t.base     = WIDTH'(l);
      t.len      = WIDTH'(r11 >> l[4:0]);
      t.addr     = t.base + (t.len >> l[7:5]);
      // low byte of rotl(l,5)
      t.new_base = t.base + WIDTH'({l[2:0], l[31:27]});
      t.new_len  = t.len >> 1;
    end
    return t;
  endfunction

  always_comb begin
    start_ok      = start && (state == IDLE || state == DONE);
    xfer          = out_valid && out_ready;
    rsp_acc       = rsp_valid && outstanding != 4'd0;
    issuing       = state == CORNER || state == RANDOM;
    stop          = STOP_ON_FAIL && issuing && rsp_acc && !rsp_ok && !fail_latched;
    outstanding_n = outstanding + 4'(xfer) - 4'(rsp_acc);
    idx_n         = start_ok ? '0 : xfer ? idx + IW'(1) : idx;
    lfsr_n        = start_ok ? SEED
                  : (xfer && state == RANDOM) ? ((lfsr >> 1) ^ (lfsr[0] ? TAPS : 32'h0)) : lfsr;
    // a tuple still held in DRAIN must transfer (and be answered) before DONE
    state_n       = start_ok ? CORNER
                  : stop ? DRAIN
                  : (state == CORNER && xfer && idx == IW'(7)) ? RANDOM
                  : (state == RANDOM && xfer && idx == IW'(NUM_VECTORS - 1)) ? DRAIN
                  : (state == DRAIN && outstanding_n == 4'd0 && !out_valid) ? DONE
                  : state;
    hold          = out_valid && !xfer;
    valid_n       = hold || ((state_n == CORNER || state_n == RANDOM) && outstanding_n < 4'(MAX_OUTSTANDING));
    tup_n         = gen(idx_n, lfsr_n);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state           <= IDLE;
      busy            <= 1'b0;
      done            <= 1'b0;
      idx             <= '0;
      lfsr            <= '0;
      outstanding     <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      out_valid       <= 1'b0;
      out_base        <= '0;
      out_len         <= '0;
      out_addr        <= '0;
      out_newBase     <= '0;
      out_newLen      <= '0;
      pass_count      <= '0;
      fail_count      <= '0;
      first_fail_base <= '0;
      first_fail_len  <= '0;
      first_fail_addr <= '0;
      proto_err       <= 1'b0;
      fail_latched    <= 1'b0;
      for (int k = 0; k < DEPTH; k++) fifo[k] <= '0;
    end else begin
      state       <= state_n;
      busy        <= state_n == CORNER || state_n == RANDOM || state_n == DRAIN;
      done        <= state_n == DONE;
      idx         <= idx_n;
      lfsr        <= lfsr_n;
      outstanding <= outstanding_n;
      out_valid   <= valid_n;
      if (valid_n && !hold) begin
        out_base    <= tup_n.base;
        out_len     <= tup_n.len;
        out_addr    <= tup_n.addr;
        out_newBase <= tup_n.new_base;
        out_newLen  <= tup_n.new_len;
      end
      if (xfer) begin
        fifo[wr_ptr] <= '{out_base, out_len, out_addr};
        wr_ptr       <= wr_ptr == PW'(MAX_OUTSTANDING - 1) ? '0 : wr_ptr + PW'(1);
      end
      if (rsp_acc) rd_ptr <= rd_ptr == PW'(MAX_OUTSTANDING - 1) ? '0 : rd_ptr + PW'(1);
      pass_count <= pass_count + 16'(rsp_acc && rsp_ok && pass_count != 16'hFFFF);
      fail_count <= fail_count + 16'(rsp_acc && !rsp_ok && fail_count != 16'hFFFF);
      if (rsp_acc && !rsp_ok && !fail_latched) begin
        fail_latched    <= 1'b1;
        first_fail_base <= fifo[rd_ptr].base;
        first_fail_len  <= fifo[rd_ptr].len;
        first_fail_addr <= fifo[rd_ptr].addr;
      end
      if (rsp_valid && outstanding == 4'd0) proto_err <= 1'b1;
      if (start_ok) begin
        pass_count      <= '0;
        fail_count      <= '0;
        first_fail_base <= '0;
        first_fail_len  <= '0;
        first_fail_addr <= '0;
        proto_err       <= 1'b0;
        fail_latched    <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_cap_prop_stim_gen.sv
// tb_cap_prop_stim_gen: directed bench for cap_prop_stim_gen with a scripted in-order responder
module tb_cap_prop_stim_gen;
  localparam logic [31:0] SEED = 32'hACE1_0001;
  localparam logic [31:0] CB [8] = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'h1000, 32'h8000_0000, 32'h1, 32'h1234_5678, 32'hFFFF_F000};
  localparam logic [31:0] CL [8] = '{32'h0, 32'hFFFF_FFFF, 32'h1, 32'hFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1_0000, 32'h1000};
  localparam logic [31:0] CA [8] = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'h1800, 32'hFFFF_FFFF, 32'h0, 32'h1235_5678, 32'hFFFF_FFFF};

  logic        clk = 1'b0;
  logic        rst_n = 1'b1, start = 1'b0, out_ready = 1'b0, rsp_valid = 1'b0, rsp_ok = 1'b0;
  logic        busy, done, out_valid, proto_err;
  logic [31:0] out_base, out_len, out_addr, out_new_base, out_new_len;
  logic [31:0] ff_base, ff_len, ff_addr;
  logic [15:0] pass_count, fail_count;

  int   n_tests = 0, n_fail = 0, ticks = 0, pend = 0, n_resp = 0, fail_idx = -1, max_pend = 0, last_rsp_tick = 0;
  logic ready_req = 1'b0, start_req = 1'b0, hold_rsp = 1'b0, one_rsp = 1'b0, proto_rsp = 1'b0;
  logic [159:0] issued [$];

  wire [159:0] tup  = {out_base, out_len, out_addr, out_new_base, out_new_len};
  wire [291:0] outs = {busy, done, out_valid, tup, pass_count, fail_count, ff_base, ff_len, ff_addr, proto_err};

  always #5 clk = ~clk;

  cap_prop_stim_gen #(.WIDTH(32), .NUM_VECTORS(16), .MAX_OUTSTANDING(4), .SEED(SEED), .STOP_ON_FAIL(1'b1)) dut (
    .CLK(clk), .RST_N(rst_n), .start(start), .busy(busy), .done(done),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_base(out_base), .out_len(out_len), .out_addr(out_addr), .out_newBase(out_new_base), .out_newLen(out_new_len),
    .rsp_valid(rsp_valid), .rsp_ok(rsp_ok), .pass_count(pass_count), .fail_count(fail_count),
    .first_fail_base(ff_base), .first_fail_len(ff_len), .first_fail_addr(ff_addr), .proto_err(proto_err)
  );

  task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [159:0] exp_tuple(input int k);
    logic [31:0] l, b, n, a, r;
    if (k < 8) return {CB[k], CL[k], CA[k], CB[k] + 32'd1, CL[k]};
    l = SEED;
    for (int j = 8; j < k; j++) l = l[0] ? (l >> 1) ^ 32'h8020_0003 : l >> 1;
    r = (l << 11) | (l >> 21);
    n = r >> l[4:0];
    b = l;
    a = b + (n >> l[7:5]);
    return {b, n, a, b + (((l << 5) | (l >> 27)) & 32'hFF), n >> 1};
  endfunction

  // one cycle: inputs change at the falling edge; a transfer is logged when it will be sampled next rising edge
  task automatic tick();
    @(negedge clk);
    ticks++;
    out_ready = ready_req;
    start     = start_req;
    start_req = 1'b0;
    rsp_valid = 1'b0;
    rsp_ok    = 1'b1;
    if (proto_rsp) begin
      rsp_valid = 1'b1;
      proto_rsp = 1'b0;
    end else if (pend > 0 && (!hold_rsp || one_rsp)) begin
      rsp_valid     = 1'b1;
      rsp_ok        = n_resp != fail_idx;
      n_resp++;
      pend--;
      one_rsp       = 1'b0;
      last_rsp_tick = ticks;
    end
    if (out_valid && out_ready) begin
      issued.push_back(tup);
      pend++;
    end
    if (pend > max_pend) max_pend = pend;
  endtask

  task automatic begin_run();
    issued.delete();
    pend      = 0;
    n_resp    = 0;
    max_pend  = 0;
    start_req = 1'b1;
    tick();
    tick();
  endtask

  task automatic run_to_done();
    int t = 0;
    while (!done && t < 400) begin
      tick();
      t++;
    end
    check("run_done", 320'(done), 320'(1));
  endtask

  task automatic check_all();
    for (int k = 0; k < issued.size(); k++)
      check($sformatf("tuple%0d", k), 320'(issued[k]), 320'(exp_tuple(k)));
  endtask

  initial begin
    int t;
    #3 rst_n = 1'b0;
    #1 check("rst_outs", 320'(outs), 320'(0));
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("idle_outs", 320'(outs), 320'(0));
    proto_rsp = 1'b1;
    tick();
    tick();
    check("proto_idle", 320'(proto_err), 320'(1));
    check("proto_cnt", 320'({pass_count, fail_count}), 320'(0));

    ready_req = 1'b1;
    begin_run();
    check("first_valid", 320'(out_valid), 320'(1));
    check("proto_clr", 320'(proto_err), 320'(0));
    check("busy_run", 320'(busy), 320'(1));
    run_to_done();
    check("done_lat", 320'(ticks), 320'(last_rsp_tick + 1));
    check("n_issued", 320'(issued.size()), 320'(16));
    check("corner0", 320'(issued[0]), 320'({32'h0, 32'h0, 32'h0, 32'h1, 32'h0}));
    check("corner3", 320'(issued[3]), 320'({32'h1000, 32'hFFF, 32'h1800, 32'h1001, 32'hFFF}));
    check_all();
    check("pass16", 320'(pass_count), 320'(16));
    check("fail0", 320'(fail_count), 320'(0));
    check("busy_done", 320'(busy), 320'(0));

    begin_run();
    t = 0;
    while (issued.size() < 2 && t < 50) begin
      tick();
      t++;
    end
    ready_req = 1'b0;
    repeat (5) begin
      tick();
      check("stall_vld", 320'(out_valid), 320'(1));
      check("stall_fld", 320'(tup), 320'({32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFF, 32'h0, 32'h1}));
    end
    check("stall_cnt", 320'(issued.size()), 320'(2));
    ready_req = 1'b1;
    tick();
    check("stall_xfer", 320'(issued.size()), 320'(3));
    run_to_done();
    check("stall_n", 320'(issued.size()), 320'(16));
    check_all();
    check("stall_pass", 320'(pass_count), 320'(16));

    hold_rsp = 1'b1;
    begin_run();
    repeat (12) tick();
    check("wh_cnt", 320'(issued.size()), 320'(4));
    check("wh_vld", 320'(out_valid), 320'(0));
    check("wh_max", 320'(max_pend), 320'(4));
    one_rsp = 1'b1;
    tick();
    tick();
    check("wh_reissue", 320'(issued.size()), 320'(5));
    repeat (4) tick();
    check("wh_cnt2", 320'(issued.size()), 320'(5));
    check("wh_vld2", 320'(out_valid), 320'(0));
    hold_rsp = 1'b0;
    run_to_done();
    check("wh_n", 320'(issued.size()), 320'(16));
    check("wh_pass", 320'(pass_count), 320'(16));
    check("wh_bound", 320'(max_pend <= 4), 320'(1));

    fail_idx = 4;
    begin_run();
    run_to_done();
    fail_idx = -1;
    check("ff_tuple", 320'({ff_base, ff_len, ff_addr}), 320'({32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF}));
    check("ff_fails", 320'(fail_count), 320'(1));
    check("ff_pass", 320'(pass_count), 320'(5));
    check("ff_issued", 320'(issued.size()), 320'(6));
    check("ff_limit", 320'(issued.size() <= 8), 320'(1));
    check_all();

    proto_rsp = 1'b1;
    tick();
    tick();
    check("proto_done", 320'(proto_err), 320'(1));
    check("proto_keep", 320'({pass_count, fail_count}), 320'({16'd5, 16'd1}));
    begin_run();
    check("proto_clr2", 320'(proto_err), 320'(0));
    run_to_done();
    check("rerun_pass", 320'(pass_count), 320'(16));

    begin_run();
    t = 0;
    while (issued.size() < 10 && t < 100) begin
      tick();
      t++;
    end
    hold_rsp = 1'b1;
    while (pend < 3 && t < 100) begin
      tick();
      t++;
    end
    ready_req = 1'b0;
    tick();
    check("mid_busy", 320'(busy), 320'(1));
    #2 rst_n = 1'b0;
    #1 check("rst_mid", 320'(outs), 320'(0));
    tick();
    rst_n    = 1'b1;
    hold_rsp = 1'b0;
    ready_req = 1'b1;
    tick();
    check("rst_idle", 320'(outs), 320'(0));
    begin_run();
    run_to_done();
    check("replay_n", 320'(issued.size()), 320'(16));
    check_all();
    check("replay_pass", 320'(pass_count), 320'(16));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
